fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the pipelined CPU front end. Owns the program counter and drives the address of the combinational, word-addressed instruction ROM. Buffers fetched words in a 2-entry queue and hands them to decode over a valid/ready handshake. Handles branch redirects, halt requests and out-of-range or misaligned fetch faults, so the ROM itself never receives an illegal address from the core.

## Interface
- MEM_BYTES, 1024, instruction ROM size in bytes; power of two, > 4
- RESET_PC, 64'd0, PC loaded on reset; must be word-aligned
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- imem_addr  out  64  byte address to instruction ROM; always equals the PC register
- imem_instr  in  32  instruction word returned combinationally for imem_addr
- redirect_valid  in  1  branch/flush request for the current cycle
- redirect_pc  in  64  new PC when redirect_valid=1
- halt_req  in  1  stop fetching after this cycle
- out_valid  out  1  out_instr/out_pc hold a valid entry
- out_ready  in  1  decode accepts the entry this cycle
- out_instr  out  32  head-of-queue instruction
- out_pc  out  64  byte address of out_instr
- halted  out  1  FSM in HALTED
- fault  out  1  FSM in FAULT (sticky)

## Operation
- States: IDLE, FETCH, HALTED, FAULT.
- IDLE: entered on reset. Moves to FETCH on the first posedge after reset deasserts. No push.
- FETCH, in priority order each cycle:
  - redirect_valid, redirect_pc[1:0]≠0: flush queue, go to FAULT.
  - redirect_valid, aligned: flush queue, PC←redirect_pc, no push.
  - halt_req: go to HALTED, no push, PC unchanged, queue kept.
  - PC+3 ≥ MEM_BYTES: go to FAULT, no push, queue kept.
  - Otherwise push {PC, imem_instr} and set PC←PC+4, only when count<2 or a pop occurs this cycle.
- HALTED:
  - Queue drains normally; no pushes.
  - An aligned redirect flushes the queue, loads PC and returns to FETCH.
  - A misaligned redirect goes to FAULT.
  - halt_req is ignored.
- FAULT:
  - Terminal until reset; no pushes.
  - Remaining entries still drain.
  - Redirects are ignored.
- Queue:
  - 2-entry FIFO with count 0..2. pop = out_valid & out_ready.
  - Simultaneous push and pop is legal at any count, including 2; count is unchanged.
  - A flush overrides a same-cycle pop: count←0, and the popped entry is still considered consumed by decode.
- PC arithmetic: 64-bit, modulo 2^64. The range check uses the full 64-bit PC, so a wrapped PC faults.
- out_instr/out_pc are don't-care when out_valid=0; bench must not check them.

## Timing
- Reset (asynchronous, active-low): state=IDLE, PC=RESET_PC, count=0, out_valid=0, halted=0, fault=0. imem_addr=RESET_PC while reset is asserted.
- Fetch start: first push at the 2nd posedge after reset release; out_valid=1 immediately after that edge.
- Fetch-to-output latency: 1 edge. An entry pushed at edge N is visible at the head after N if the queue was empty.
- Sustained throughput: 1 instruction/cycle with out_ready held at 1.
- Redirect at edge N: out_valid=0 after N. Target word is pushed at N+1; out_valid=1 after N+1. One bubble.
- Backpressure: with out_ready=0 the queue fills in 2 cycles, then PC holds. The first pop lets a push occur in the same cycle with no bubble.
- Halt at edge N: halted=1 after N.
- Fault entry at edge N: fault=1 after N.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); in-flight entries are lost.

## Test plan
- Reset release, ROM words 0..3 = A,B,C,D, out_ready=1 → out_pc 0,4,8,12 with instr A,B,C,D on consecutive cycles; first out_valid after the 2nd edge.
- out_ready=0 for 5 cycles after start → count saturates at 2, imem_addr stays 8, out_pc=0. Raise out_ready → 0,4,8 on back-to-back cycles with no bubble.
- Redirect to 0x40 while the queue holds 2 entries → out_valid=0 for one cycle, then out_pc=0x40, 0x44. Old entries never appear.
- halt_req at PC=0x10 with 2 queued → both drain, halted=1, imem_addr holds 0x10. Redirect to 0x0 → halted=0, fetch resumes at 0.
- Sequential run to PC=MEM_BYTES-4=0x3FC → entry 0x3FC delivered, then fault=1 with no further pushes. Redirect to 0x6 from FETCH → fault=1 and queue flushed.
- Assert reset mid-stream with 2 queued → out_valid=0, imem_addr=RESET_PC asynchronously. The fetch sequence restarts after release.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, drives the combinational ROM address,
// and buffers fetched words in a 2-entry queue toward decode.
module fetch_sequencer #(
  parameter int unsigned MEM_BYTES = 1024,
  parameter logic [63:0] RESET_PC  = 64'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt_req,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [63:0] out_pc,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {IDLE, FETCH, HALTED, FAULT} state_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t       state, nxt_state;
  logic [63:0]  pc;
  entry_t [1:0] q;
  logic [1:0]   count;
  entry_t       new_entry;

  logic pop, push, flush, load;
  logic redir_ok, redir_bad, in_range;

  assign imem_addr = pc;
  assign out_valid = (count != 2'd0);
  assign out_instr = q[0].instr;
  assign out_pc    = q[0].pc;
  assign new_entry = '{pc: pc, instr: imem_instr};

  assign pop       = out_valid & out_ready;
  assign redir_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
  assign redir_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
  // 65-bit sum so the last word's check cannot wrap around
  assign in_range  = ({1'b0, pc} + 65'd3) < 65'(MEM_BYTES);

  always_comb begin
    nxt_state = state;
    flush     = 1'b0;
    push      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: nxt_state = FETCH;
      FETCH: begin
        if (redir_bad) begin
          flush     = 1'b1;
          nxt_state = FAULT;
        end else if (redir_ok) begin
          flush = 1'b1;
          load  = 1'b1;
        end else if (halt_req) begin
          nxt_state = HALTED;
        end else if (!in_range) begin
          nxt_state = FAULT;
        end else begin
          push = (count != 2'd2) | pop;
        end
      end
      HALTED: begin
        if (redir_bad) begin
          nxt_state = FAULT;
        end else if (redir_ok) begin
          flush     = 1'b1;
          load      = 1'b1;
          nxt_state = FETCH;
        end
      end
      default: nxt_state = FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      count  <= 2'd0;
      q      <= '0;
      halted <= 1'b0;
      fault  <= 1'b0;
    end else begin
      state  <= nxt_state;
      halted <= (nxt_state == HALTED);
      fault  <= (nxt_state == FAULT);

      if (load)      pc <= redirect_pc;
      else if (push) pc <= pc + 64'd4;

      // Flush wins over a same-cycle pop; the popped entry is already consumed
      if (flush) begin
        count <= 2'd0;
      end else begin
        case ({push, pop})
          2'b11: begin
            if (count == 2'd2) begin
              q[0] <= q[1];
              q[1] <= new_entry;
            end else begin
              q[0] <= new_entry;
            end
          end
          2'b10: begin
            if (count == 2'd0) q[0] <= new_entry;
            else               q[1] <= new_entry;
            count <= count + 2'd1;
          end
          2'b01: begin
            q[0]  <= q[1];
            count <= count - 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: stimulus queues expected {pc, instr},
// a negedge monitor pops and compares every accepted output entry.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [63:0] out_pc;
  logic        halted;
  logic        fault;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [63:0] a);
    return 32'hA500_0000 | {8'h00, a[23:0]};
  endfunction

  assign imem_instr = rom(imem_addr);

  fetch_sequencer #(.MEM_BYTES(1024), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt_req(halt_req),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .halted(halted), .fault(fault)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [63:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = rom(pc);
    exp_q.push_back(e);
  endtask

  // Reset pulse aligned so the next posedge after return is "edge 1"
  task automatic do_reset();
    reset = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_entry: got pc %h instr %h, expected no entry", out_pc, out_instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          fails++;
          $display("FAIL entry: got pc %h instr %h, expected pc %h instr %h",
                   out_pc, out_instr, e.pc, e.instr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt_req = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check("rst_addr", imem_addr, 64'h0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    check("rst_fault", {63'd0, fault}, 64'd0);

    // Streaming start: 0,4,8,12 on consecutive cycles
    reset = 1'b1;
    push_exp(64'h0); push_exp(64'h4); push_exp(64'h8); push_exp(64'hC);
    tick();
    check("start_edge1_valid", {63'd0, out_valid}, 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", {63'd0, out_valid}, 64'd1);
      tick();
    end
    out_ready = 1'b0;
    check("stream_drained", exp_q.size(), 64'd0);

    // Backpressure: queue saturates at 2, PC holds at 8
    do_reset();
    tick(); tick();
    check("bp_addr_e2", imem_addr, 64'h4);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("bp_addr_hold", imem_addr, 64'h8);
      tick();
    end
    check("bp_valid", {63'd0, out_valid}, 64'd1);
    check("bp_head_pc", out_pc, 64'h0);
    push_exp(64'h0); push_exp(64'h4); push_exp(64'h8);
    out_ready = 1'b1;
    tick();
    check("bp_nobubble1", {63'd0, out_valid}, 64'd1);
    tick();
    check("bp_nobubble2", {63'd0, out_valid}, 64'd1);
    tick();
    out_ready = 1'b0;
    check("bp_drained", exp_q.size(), 64'd0);

    // Redirect with 2 queued: one bubble, old entries dropped
    redirect_valid = 1'b1; redirect_pc = 64'h40;
    tick();
    redirect_valid = 1'b0;
    check("redir_bubble", {63'd0, out_valid}, 64'd0);
    check("redir_addr", imem_addr, 64'h40);
    exp_q.delete();
    push_exp(64'h40); push_exp(64'h44);
    out_ready = 1'b1;
    tick();
    check("redir_valid", {63'd0, out_valid}, 64'd1);
    tick(); tick();
    out_ready = 1'b0;
    check("redir_drained", exp_q.size(), 64'd0);

    // Halt at PC=0x10 with 8,C queued
    do_reset();
    out_ready = 1'b0;
    tick(); tick(); tick();
    push_exp(64'h0); push_exp(64'h4);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    halt_req = 1'b1;
    check("halt_pc", imem_addr, 64'h10);
    tick();
    halt_req = 1'b0;
    check("halted_set", {63'd0, halted}, 64'd1);
    check("halt_keep_q", {63'd0, out_valid}, 64'd1);
    push_exp(64'h8); push_exp(64'hC);
    out_ready = 1'b1;
    halt_req = 1'b1;
    tick(); tick();
    halt_req = 1'b0;
    tick();
    check("halt_drained_valid", {63'd0, out_valid}, 64'd0);
    check("halt_addr_hold", imem_addr, 64'h10);
    check("halt_still", {63'd0, halted}, 64'd1);
    check("halt_drained", exp_q.size(), 64'd0);
    redirect_valid = 1'b1; redirect_pc = 64'h0;
    tick();
    redirect_valid = 1'b0;
    check("unhalt", {63'd0, halted}, 64'd0);
    check("unhalt_addr", imem_addr, 64'h0);
    push_exp(64'h0); push_exp(64'h4);
    tick();
    check("unhalt_valid", {63'd0, out_valid}, 64'd1);
    tick(); tick();
    out_ready = 1'b0;
    check("unhalt_drained", exp_q.size(), 64'd0);

    // Sequential run to the end of ROM, then fault
    do_reset();
    out_ready = 1'b1;
    for (int a = 0; a < 1024; a += 4) push_exp(64'(a));
    for (int i = 0; i < 400 && !fault; i++) tick();
    check("end_fault", {63'd0, fault}, 64'd1);
    check("end_addr", imem_addr, 64'h400);
    tick(); tick();
    check("end_no_push", {63'd0, out_valid}, 64'd0);
    check("end_drained", exp_q.size(), 64'd0);

    // Misaligned redirect from FETCH with 2 queued
    do_reset();
    out_ready = 1'b0;
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_pc = 64'h6;
    tick();
    check("mis_fault", {63'd0, fault}, 64'd1);
    check("mis_flush", {63'd0, out_valid}, 64'd0);
    redirect_pc = 64'h40;
    tick();
    redirect_valid = 1'b0;
    check("fault_sticky", {63'd0, fault}, 64'd1);
    check("fault_ignore_redir", imem_addr, 64'h8);

    // Asynchronous reset mid-stream
    do_reset();
    out_ready = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_valid", {63'd0, out_valid}, 64'd0);
    check("async_addr", imem_addr, 64'h0);
    exp_q.delete();
    tick();
    reset = 1'b1;
    push_exp(64'h0); push_exp(64'h4);
    out_ready = 1'b1;
    tick();
    tick();
    check("restart_valid", {63'd0, out_valid}, 64'd1);
    tick();
    tick();
    out_ready = 1'b0;
    check("restart_drained", exp_q.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
